// File: rtl/fetch_stage.sv
// IF stage: owns PCF, fetches over a single-outstanding req/gnt/rvalid port and fills the IF/ID register.
// Optional FETCH_PERF_EN adds FetchCnt/DiscardCnt performance counters.
`timescale 1ns/1ps
module fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusyF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     FetchCnt,
  output logic [31:0]     DiscardCnt
`endif
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DISCARD} state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] reqPC;
  logic [XLEN-1:0] reqPlus4;
  logic [31:0]     holdInstr;
  logic [31:0]     loadInstr;
  logic            loadNew;
  logic            dropResp;

  always_comb begin
    imem_req   = (state == REQ) && !StallF && !PCSrcE;
    imem_addr  = pcF;
    FetchBusyF = (state != REQ);
    reqPlus4   = reqPC + FOUR;
    // A redirect in the same cycle always wins over delivering a fetched instruction.
    loadNew    = !PCSrcE && !StallD &&
                 (((state == WAIT) && imem_rvalid) || (state == HOLD));
    loadInstr  = (state == HOLD) ? holdInstr : imem_rdata;
    dropResp   = ((state == WAIT) && imem_rvalid && PCSrcE) ||
                 ((state == HOLD) && PCSrcE) ||
                 ((state == DISCARD) && imem_rvalid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REQ;
      pcF       <= RESET_PC;
      reqPC     <= '0;
      holdInstr <= '0;
    end else begin
      case (state)
        REQ: begin
          if (imem_req && imem_gnt) begin
            reqPC <= pcF;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (PCSrcE) begin
              state <= REQ;
            end else if (!StallD) begin
              pcF   <= reqPlus4;
              state <= REQ;
            end else begin
              holdInstr <= imem_rdata;
              pcF       <= reqPlus4;
              state     <= HOLD;
            end
          end else if (PCSrcE) begin
            state <= DISCARD;
          end
        end
        HOLD: begin
          if (PCSrcE || !StallD) state <= REQ;
        end
        DISCARD: begin
          if (imem_rvalid) state <= REQ;
        end
        default: state <= REQ;
      endcase
      // Placed last so the redirect target overrides any sequential PC update above.
      if (PCSrcE) pcF <= PCTargetE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (loadNew) begin
      InstrD   <= loadInstr;
      PCD      <= reqPC;
      PCPlus4D <= reqPlus4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCnt   <= '0;
      DiscardCnt <= '0;
    end else begin
      if (loadNew && !FlushD) FetchCnt <= FetchCnt + 32'd1;
      if (dropResp) DiscardCnt <= DiscardCnt + 32'd1;
    end
  end
`else
  logic unusedDrop;
  assign unusedDrop = dropResp;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: transaction-level model feeds a scoreboard queue of expected IF/ID contents.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusyF;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusyF(FetchBusyF)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  ifid_t expQ[$];
  int    total = 0;
  int    bad = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected IF/ID snapshot per clock after reset release.
  initial begin
    ifid_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("ValidD", {31'd0, ValidD}, {31'd0, e.v});
        chk("InstrD", InstrD, e.instr);
        chk("PCD", PCD, e.pc);
        chk("PCPlus4D", PCPlus4D, e.pc4);
      end
    end
  end

  // Model state: a fetch is outstanding from grant to response, then held until decode takes it.
  logic        mOut, mKilled, mHeld;
  logic [31:0] mOutAddr, mHeldAddr, mNext;
  ifid_t       expIfid;
  logic        memBusy;
  int          memCnt;
  logic [31:0] memAddr;

  initial begin
    logic        busy, expReq, deliver, quiet;
    logic [31:0] tmp;
    StallF = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mOut = 1'b0; mKilled = 1'b0; mHeld = 1'b0; mOutAddr = '0; mHeldAddr = '0; mNext = 32'h0;
    expIfid = '{v: 1'b0, instr: NOP, pc: 32'h0, pc4: 32'h0};
    memBusy = 1'b0; memCnt = 0; memAddr = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_busy", {31'd0, FetchBusyF}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (memBusy) begin
        memCnt--;
        if (memCnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memWord(memAddr);
          memBusy     = 1'b0;
        end
      end
      quiet  = (cyc < 30);
      StallF = !quiet && ($urandom_range(0, 4) == 0);
      StallD = !quiet && ($urandom_range(0, 3) == 0);
      FlushD = !quiet && ($urandom_range(0, 9) == 0);
      PCSrcE = !quiet && ($urandom_range(0, 11) == 0);
      tmp = $urandom;
      case ($urandom_range(0, 3))
        0:       PCTargetE = 32'h0000_0100;
        1:       PCTargetE = 32'hFFFF_FFFC;
        default: PCTargetE = tmp & 32'hFFFF_FFFC;
      endcase
      imem_gnt = quiet || ($urandom_range(0, 9) < 7);
      #1;

      busy   = mOut || mHeld;
      expReq = !busy && !StallF && !PCSrcE;
      chk("FetchBusyF", {31'd0, FetchBusyF}, {31'd0, busy});
      chk("imem_req", {31'd0, imem_req}, {31'd0, expReq});
      if (expReq) chk("imem_addr", imem_addr, mNext);

      deliver = 1'b0;
      if (mOut && imem_rvalid) begin
        mOut = 1'b0;
        if (!mKilled && !PCSrcE) begin
          mHeld     = 1'b1;
          mHeldAddr = mOutAddr;
          mNext     = mOutAddr + 32'd4;
        end
      end
      if (mHeld && PCSrcE) begin
        mHeld = 1'b0;
      end else if (mHeld && !StallD) begin
        deliver = 1'b1;
        mHeld   = 1'b0;
      end
      if (PCSrcE) begin
        mNext = PCTargetE;
        if (mOut) mKilled = 1'b1;
      end

      if (FlushD) begin
        expIfid.v     = 1'b0;
        expIfid.instr = NOP;
      end else if (!StallD) begin
        if (deliver) begin
          expIfid = '{v: 1'b1, instr: memWord(mHeldAddr), pc: mHeldAddr, pc4: mHeldAddr + 32'd4};
        end else begin
          expIfid.v     = 1'b0;
          expIfid.instr = NOP;
        end
      end

      if (expReq && imem_gnt) begin
        mOut     = 1'b1;
        mKilled  = 1'b0;
        mOutAddr = mNext;
      end
      expQ.push_back(expIfid);

      if (imem_req && imem_gnt) begin
        memBusy = 1'b1;
        memAddr = imem_addr;
        memCnt  = $urandom_range(1, 3);
      end
    end

    @(negedge clk);
    chk("scoreboard_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
